// File: rtl/mprc_hella_cache.sv
// rtl/mprc_hella_cache.sv - blocking write-back direct-mapped L1 data cache (option macro: MPRC_HC_MISALIGN_XCPT_EN)
module mprc_hella_cache #(
  parameter int LINES = 16,
  parameter int TAG_W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_cpu_req_valid,
  output logic         io_cpu_req_ready,
  input  logic [39:0]  io_cpu_req_bits_addr,
  input  logic [8:0]   io_cpu_req_bits_tag,
  input  logic [4:0]   io_cpu_req_bits_cmd,
  input  logic [2:0]   io_cpu_req_bits_typ,
  input  logic [63:0]  io_cpu_req_bits_data,
  input  logic         io_cpu_req_bits_kill,
  output logic         io_cpu_resp_valid,
  output logic [39:0]  io_cpu_resp_bits_addr,
  output logic [8:0]   io_cpu_resp_bits_tag,
  output logic [4:0]   io_cpu_resp_bits_cmd,
  output logic [2:0]   io_cpu_resp_bits_typ,
  output logic [63:0]  io_cpu_resp_bits_data,
  output logic         io_cpu_resp_bits_has_data,
  output logic [63:0]  io_cpu_resp_bits_store_data,
  output logic         io_cpu_xcpt_ma_ld,
  output logic         io_cpu_xcpt_ma_st,
  output logic         io_mem_acquire_valid,
  input  logic         io_mem_acquire_ready,
  output logic [25:0]  io_mem_acquire_bits_addr_block,
  output logic [1:0]   io_mem_acquire_bits_client_xact_id,
  output logic [1:0]   io_mem_acquire_bits_addr_beat,
  output logic         io_mem_acquire_bits_is_builtin_type,
  output logic [2:0]   io_mem_acquire_bits_a_type,
  output logic [16:0]  io_mem_acquire_bits_union,
  output logic [127:0] io_mem_acquire_bits_data,
  input  logic         io_mem_grant_valid,
  output logic         io_mem_grant_ready,
  input  logic [1:0]   io_mem_grant_bits_addr_beat,
  input  logic [1:0]   io_mem_grant_bits_client_xact_id,
  input  logic [3:0]   io_mem_grant_bits_manager_xact_id,
  input  logic         io_mem_grant_bits_is_builtin_type,
  input  logic [3:0]   io_mem_grant_bits_g_type,
  input  logic [127:0] io_mem_grant_bits_data,
  output logic         io_mem_release_valid,
  input  logic         io_mem_release_ready,
  output logic [1:0]   io_mem_release_bits_addr_beat,
  output logic [25:0]  io_mem_release_bits_addr_block,
  output logic [1:0]   io_mem_release_bits_client_xact_id,
  output logic         io_mem_release_bits_voluntary,
  output logic [2:0]   io_mem_release_bits_r_type,
  output logic [127:0] io_mem_release_bits_data
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {IDLE, S1, WB, ACQ, REFILL, REPLAY} state_e;
  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [511:0]     line_q [LINES];

  logic [39:0]      addr_q;
  logic [8:0]       rtag_q;
  logic [4:0]       cmd_q;
  logic [2:0]       typ_q;
  logic [63:0]      sdata_q;
  logic [1:0]       beat_q;
  logic             resp_valid_q;
  logic [63:0]      resp_data_q;

  logic             req_fire, grant_fire, refill_last, do_access, xcpt, is_store, hit;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       lg;
  logic [5:0]       amask, off;
  logic [63:0]      bm64, dword, sh, load_data;
  logic [511:0]     cur_line, wmask, wdata, merged;
  logic             unused_grant;

  assign unused_grant = ^{io_mem_grant_bits_client_xact_id, io_mem_grant_bits_manager_xact_id,
                          io_mem_grant_bits_is_builtin_type, io_mem_grant_bits_g_type};

  assign req_fire    = io_cpu_req_valid && io_cpu_req_ready;
  assign grant_fire  = (state_q == REFILL) && io_mem_grant_valid;
  assign refill_last = grant_fire && (beat_q == 2'd3);
  assign idx         = addr_q[6 +: IDX_W];
  assign req_tag     = addr_q[6+IDX_W +: TAG_W];
  assign lg          = typ_q[1:0];
  assign is_store    = (cmd_q == 5'd1);
  assign cur_line    = line_q[idx];
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);

  // Access size decode: alignment mask and byte-lane mask for stores
  always_comb begin
    amask = 6'd7;
    bm64  = '1;
    case (lg)
      2'd0: begin amask = 6'd0; bm64 = 64'h0000_0000_0000_00ff; end
      2'd1: begin amask = 6'd1; bm64 = 64'h0000_0000_0000_ffff; end
      2'd2: begin amask = 6'd3; bm64 = 64'h0000_0000_ffff_ffff; end
      default: begin amask = 6'd7; bm64 = '1; end
    endcase
  end

`ifdef MPRC_HC_MISALIGN_XCPT_EN
  logic misaligned;
  assign misaligned = |(addr_q[5:0] & amask);
  assign off        = addr_q[5:0];
`else
  assign off        = addr_q[5:0] & ~amask;
`endif

  assign dword  = cur_line[{off[5:3], 6'b0} +: 64];
  assign sh     = dword >> {off[2:0], 3'b0};
  assign wmask  = {448'b0, bm64} << {off, 3'b0};
  assign wdata  = {448'b0, sdata_q} << {off, 3'b0};
  assign merged = (cur_line & ~wmask) | (wdata & wmask);

  // Sign/zero extension of the addressed bytes
  always_comb begin
    load_data = sh;
    case (typ_q)
      3'd0: load_data = {{56{sh[7]}}, sh[7:0]};
      3'd1: load_data = {{48{sh[15]}}, sh[15:0]};
      3'd2: load_data = {{32{sh[31]}}, sh[31:0]};
      3'd4: load_data = {56'b0, sh[7:0]};
      3'd5: load_data = {48'b0, sh[15:0]};
      3'd6: load_data = {32'b0, sh[31:0]};
      default: load_data = sh;
    endcase
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d              = state_q;
    do_access            = 1'b0;
    xcpt                 = 1'b0;
    io_mem_release_valid = 1'b0;
    io_mem_acquire_valid = 1'b0;
    io_mem_grant_ready   = 1'b0;
    case (state_q)
      IDLE: if (req_fire) state_d = S1;
      S1: begin
        if (io_cpu_req_bits_kill) state_d = IDLE;
`ifdef MPRC_HC_MISALIGN_XCPT_EN
        else if (misaligned) begin xcpt = 1'b1; state_d = IDLE; end
`endif
        else if (hit) begin do_access = 1'b1; state_d = IDLE; end
        else if (valid_q[idx] && dirty_q[idx]) state_d = WB;
        else state_d = ACQ;
      end
      WB: begin
        io_mem_release_valid = 1'b1;
        if (io_mem_release_ready && beat_q == 2'd3) state_d = ACQ;
      end
      ACQ: begin
        io_mem_acquire_valid = 1'b1;
        if (io_mem_acquire_ready) state_d = REFILL;
      end
      REFILL: begin
        io_mem_grant_ready = 1'b1;
        if (refill_last) state_d = REPLAY;
      end
      REPLAY: begin do_access = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request latch, beat counter, line status and response register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE; addr_q <= '0; rtag_q <= '0; cmd_q <= '0; typ_q <= '0; sdata_q <= '0;
      beat_q <= '0; valid_q <= '0; dirty_q <= '0; resp_valid_q <= 1'b0; resp_data_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= do_access;
      if (req_fire) begin
        addr_q  <= io_cpu_req_bits_addr;
        rtag_q  <= io_cpu_req_bits_tag;
        cmd_q   <= io_cpu_req_bits_cmd;
        typ_q   <= io_cpu_req_bits_typ;
        sdata_q <= io_cpu_req_bits_data;
      end
      if (state_q == S1) beat_q <= '0;
      else if ((state_q == WB && io_mem_release_ready) || grant_fire) beat_q <= beat_q + 2'd1;
      if (do_access) resp_data_q <= load_data;
      if (do_access && is_store) dirty_q[idx] <= 1'b1;
      if (refill_last) begin valid_q[idx] <= 1'b1; dirty_q[idx] <= 1'b0; end
    end
  end

  // Tag and data arrays: store merges and refill beats
  always_ff @(posedge clk) begin
    if (do_access && is_store) line_q[idx] <= merged;
    if (grant_fire) line_q[idx][{io_mem_grant_bits_addr_beat, 7'b0} +: 128] <= io_mem_grant_bits_data;
    if (refill_last) tag_q[idx] <= req_tag;
  end

  assign io_cpu_req_ready            = reset && (state_q == IDLE);
  assign io_cpu_resp_valid           = resp_valid_q;
  assign io_cpu_resp_bits_addr       = addr_q;
  assign io_cpu_resp_bits_tag        = rtag_q;
  assign io_cpu_resp_bits_cmd        = cmd_q;
  assign io_cpu_resp_bits_typ        = typ_q;
  assign io_cpu_resp_bits_data       = resp_data_q;
  assign io_cpu_resp_bits_has_data   = !is_store;
  assign io_cpu_resp_bits_store_data = sdata_q;
  assign io_cpu_xcpt_ma_ld           = xcpt && !is_store;
  assign io_cpu_xcpt_ma_st           = xcpt && is_store;

  assign io_mem_acquire_bits_addr_block      = addr_q[31:6];
  assign io_mem_acquire_bits_client_xact_id  = 2'd0;
  assign io_mem_acquire_bits_addr_beat       = 2'd0;
  assign io_mem_acquire_bits_is_builtin_type = 1'b0;
  assign io_mem_acquire_bits_a_type          = 3'd1;
  assign io_mem_acquire_bits_union           = '0;
  assign io_mem_acquire_bits_data            = '0;

  assign io_mem_release_bits_addr_beat       = beat_q;
  assign io_mem_release_bits_addr_block      = 26'({tag_q[idx], idx});
  assign io_mem_release_bits_client_xact_id  = 2'd0;
  assign io_mem_release_bits_voluntary       = 1'b1;
  assign io_mem_release_bits_r_type          = 3'd0;
  assign io_mem_release_bits_data            = cur_line[{beat_q, 7'b0} +: 128];
endmodule

// File: tb/tb_mprc_hella_cache.sv
// tb/tb_mprc_hella_cache.sv - directed self-checking bench for mprc_hella_cache (option macro: MPRC_HC_MISALIGN_XCPT_EN)
module tb_mprc_hella_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req_valid, req_ready, kill;
  logic [39:0]  req_addr;
  logic [8:0]   req_tag;
  logic [4:0]   req_cmd;
  logic [2:0]   req_typ;
  logic [63:0]  req_data;
  logic         resp_valid, resp_has_data, xcpt_ld, xcpt_st;
  logic [39:0]  resp_addr;
  logic [8:0]   resp_tag;
  logic [4:0]   resp_cmd;
  logic [2:0]   resp_typ;
  logic [63:0]  resp_data, resp_sdata;
  logic         acq_valid, acq_ready, acq_builtin;
  logic [25:0]  acq_block;
  logic [1:0]   acq_xid, acq_beat;
  logic [2:0]   acq_atype;
  logic [16:0]  acq_union;
  logic [127:0] acq_data;
  logic         gnt_valid, gnt_ready, gnt_builtin;
  logic [1:0]   gnt_beat, gnt_cxid;
  logic [3:0]   gnt_mxid, gnt_gtype;
  logic [127:0] gnt_data;
  logic         rel_valid, rel_ready, rel_vol;
  logic [1:0]   rel_beat_o, rel_xid;
  logic [25:0]  rel_block;
  logic [2:0]   rel_rtype;
  logic [127:0] rel_data_o;

  mprc_hella_cache dut (
    .clk(clk), .reset(reset),
    .io_cpu_req_valid(req_valid), .io_cpu_req_ready(req_ready),
    .io_cpu_req_bits_addr(req_addr), .io_cpu_req_bits_tag(req_tag), .io_cpu_req_bits_cmd(req_cmd),
    .io_cpu_req_bits_typ(req_typ), .io_cpu_req_bits_data(req_data), .io_cpu_req_bits_kill(kill),
    .io_cpu_resp_valid(resp_valid), .io_cpu_resp_bits_addr(resp_addr), .io_cpu_resp_bits_tag(resp_tag),
    .io_cpu_resp_bits_cmd(resp_cmd), .io_cpu_resp_bits_typ(resp_typ), .io_cpu_resp_bits_data(resp_data),
    .io_cpu_resp_bits_has_data(resp_has_data), .io_cpu_resp_bits_store_data(resp_sdata),
    .io_cpu_xcpt_ma_ld(xcpt_ld), .io_cpu_xcpt_ma_st(xcpt_st),
    .io_mem_acquire_valid(acq_valid), .io_mem_acquire_ready(acq_ready),
    .io_mem_acquire_bits_addr_block(acq_block), .io_mem_acquire_bits_client_xact_id(acq_xid),
    .io_mem_acquire_bits_addr_beat(acq_beat), .io_mem_acquire_bits_is_builtin_type(acq_builtin),
    .io_mem_acquire_bits_a_type(acq_atype), .io_mem_acquire_bits_union(acq_union),
    .io_mem_acquire_bits_data(acq_data),
    .io_mem_grant_valid(gnt_valid), .io_mem_grant_ready(gnt_ready),
    .io_mem_grant_bits_addr_beat(gnt_beat), .io_mem_grant_bits_client_xact_id(gnt_cxid),
    .io_mem_grant_bits_manager_xact_id(gnt_mxid), .io_mem_grant_bits_is_builtin_type(gnt_builtin),
    .io_mem_grant_bits_g_type(gnt_gtype), .io_mem_grant_bits_data(gnt_data),
    .io_mem_release_valid(rel_valid), .io_mem_release_ready(rel_ready),
    .io_mem_release_bits_addr_beat(rel_beat_o), .io_mem_release_bits_addr_block(rel_block),
    .io_mem_release_bits_client_xact_id(rel_xid), .io_mem_release_bits_voluntary(rel_vol),
    .io_mem_release_bits_r_type(rel_rtype), .io_mem_release_bits_data(rel_data_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Refill pattern: low half of beat b is 0x1122334455667788 + b
  function automatic logic [127:0] gdata(input logic [25:0] blk, input logic [1:0] b);
    return {6'b0, blk, 24'h0, 6'b0, b, 64'h1122334455667788 + {62'b0, b}};
  endfunction

  int           acq_n = 0;
  logic [25:0]  acq_blk_log;
  logic [2:0]   acq_type_log;
  int           rel_n = 0;
  logic [25:0]  rel_blk_log  [16];
  logic [127:0] rel_data_log [16];
  logic [1:0]   rel_beat_log [16];
  logic         rel_vol_log  [16];
  int           gpend = 0;
  int           gk;
  bit           grev = 1'b0;

  // Outer memory model: logs releases/acquires and returns four grant beats after an acquire
  always @(negedge clk) begin
    if (gpend != 0) begin
      gk        = 4 - gpend;
      gnt_valid = 1'b1;
      gnt_beat  = grev ? 2'(3 - gk) : 2'(gk);
      gnt_data  = gdata(acq_blk_log, gnt_beat);
      gpend     = gpend - 1;
    end else begin
      gnt_valid = 1'b0;
    end
    if (acq_valid && acq_ready) begin
      acq_n++;
      acq_blk_log  = acq_block;
      acq_type_log = acq_atype;
      gpend        = 4;
    end
    if (rel_valid && rel_ready && rel_n < 16) begin
      rel_blk_log[rel_n]  = rel_block;
      rel_data_log[rel_n] = rel_data_o;
      rel_beat_log[rel_n] = rel_beat_o;
      rel_vol_log[rel_n]  = rel_vol;
      rel_n++;
    end
  end

  int          lat;
  logic [63:0] rdata;
  logic [8:0]  rtag;
  logic        rhas, xld, xst, rv_after;

  task automatic do_req(input logic [39:0] a, input logic [4:0] c, input logic [2:0] t,
                        input logic [63:0] d, input logic [8:0] tg, input logic k);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_cmd = c; req_typ = t; req_data = d; req_tag = tg;
    @(negedge clk);
    xld = xcpt_ld; xst = xcpt_st;
    req_valid = 1'b0; kill = k;
    lat = -1; rv_after = 1'b0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      kill = 1'b0;
      if (lat >= 0) begin rv_after = resp_valid; break; end
      if (resp_valid) begin lat = i; rdata = resp_data; rtag = resp_tag; rhas = resp_has_data; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; kill = 1'b0; req_addr = '0; req_tag = '0; req_cmd = '0;
    req_typ = '0; req_data = '0; acq_ready = 1'b0; rel_ready = 1'b0; gnt_valid = 1'b0;
    gnt_beat = '0; gnt_cxid = '0; gnt_mxid = '0; gnt_builtin = 1'b0; gnt_gtype = '0; gnt_data = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_valids", 128'({resp_valid, acq_valid, rel_valid, gnt_ready}), 128'd0);
    reset = 1'b1;
    #1;
    check("req_ready_after_rst", 128'(req_ready), 128'd1);
    check("valids_after_rst", 128'({resp_valid, acq_valid, rel_valid, gnt_ready, xcpt_ld, xcpt_st}), 128'd0);
    acq_ready = 1'b1; rel_ready = 1'b1;

    do_req(40'h1000, 5'd0, 3'd3, 64'd0, 9'h15, 1'b0);
    check("cold_ld_lat", 128'(lat), 128'd8);
    check("cold_ld_data", 128'(rdata), 128'h1122334455667788);
    check("cold_ld_tag", 128'(rtag), 128'h15);
    check("cold_ld_has_data", 128'(rhas), 128'd1);
    check("cold_acq_n", 128'(acq_n), 128'd1);
    check("cold_acq_blk", 128'(acq_blk_log), 128'h40);
    check("cold_acq_type", 128'(acq_type_log), 128'd1);
    check("cold_rel_n", 128'(rel_n), 128'd0);

    do_req(40'h1003, 5'd1, 3'd0, 64'h80, 9'h01, 1'b0);
    check("sb_lat", 128'(lat), 128'd2);
    check("sb_has_data", 128'(rhas), 128'd0);
    check("sb_resp_one_cycle", 128'(rv_after), 128'd0);

    do_req(40'h1003, 5'd0, 3'd0, 64'd0, 9'h02, 1'b0);
    check("lb_lat", 128'(lat), 128'd2);
    check("lb_data", 128'(rdata), 128'hFFFFFFFFFFFFFF80);
    do_req(40'h1003, 5'd0, 3'd4, 64'd0, 9'h03, 1'b0);
    check("lbu_data", 128'(rdata), 128'h80);
    do_req(40'h1002, 5'd0, 3'd1, 64'd0, 9'h04, 1'b0);
    check("lh_data", 128'(rdata), 128'hFFFFFFFFFFFF8066);
    do_req(40'h1000, 5'd0, 3'd2, 64'd0, 9'h05, 1'b0);
    check("lw_data", 128'(rdata), 128'hFFFFFFFF80667788);
    do_req(40'h1000, 5'd0, 3'd6, 64'd0, 9'h06, 1'b0);
    check("lwu_data", 128'(rdata), 128'h0000000080667788);
    do_req(40'h1008, 5'd0, 3'd3, 64'd0, 9'h07, 1'b0);
    check("ld_hi_data", 128'(rdata), 128'h0000004000000000);

    do_req(40'h1002, 5'd0, 3'd2, 64'd0, 9'h08, 1'b0);
`ifdef MPRC_HC_MISALIGN_XCPT_EN
    check("ma_ld_flag", 128'(xld), 128'd1);
    check("ma_no_resp", 128'(lat), 128'hffffffffffffffffffffffffffffffff);
    check("ma_no_acq", 128'(acq_n), 128'd1);
`else
    check("ma_masked_data", 128'(rdata), 128'hFFFFFFFF80667788);
    check("ma_flags_zero", 128'({xld, xst}), 128'd0);
`endif

    do_req(40'h1000, 5'd0, 3'd3, 64'd0, 9'h09, 1'b1);
    check("kill_ld_no_resp", 128'(lat), 128'hffffffffffffffffffffffffffffffff);
    do_req(40'h1000, 5'd1, 3'd0, 64'h11, 9'h0a, 1'b1);
    check("kill_st_no_resp", 128'(lat), 128'hffffffffffffffffffffffffffffffff);
    do_req(40'h1000, 5'd0, 3'd4, 64'd0, 9'h0b, 1'b0);
    check("kill_st_unchanged", 128'(rdata), 128'h88);

    do_req(40'h1000, 5'd1, 3'd3, 64'hDEADBEEF01234567, 9'h0c, 1'b0);
    check("sd_lat", 128'(lat), 128'd2);
    do_req(40'h1000, 5'd0, 3'd3, 64'd0, 9'h0d, 1'b0);
    check("sd_readback", 128'(rdata), 128'hDEADBEEF01234567);

    grev = 1'b1;
    do_req(40'h1430, 5'd0, 3'd3, 64'd0, 9'h1ab, 1'b0);
    check("evict_lat", 128'(lat), 128'd12);
    check("evict_rel_n", 128'(rel_n), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("evict_rel%0d_blk", i), 128'(rel_blk_log[i]), 128'h40);
      check($sformatf("evict_rel%0d_beat", i), 128'(rel_beat_log[i]), 128'(i));
      check($sformatf("evict_rel%0d_vol", i), 128'(rel_vol_log[i]), 128'd1);
    end
    check("evict_rel0_data", rel_data_log[0], 128'h0000004000000000DEADBEEF01234567);
    check("evict_rel3_data", rel_data_log[3], 128'h0000004000000003112233445566778B);
    check("evict_acq_n", 128'(acq_n), 128'd2);
    check("evict_acq_blk", 128'(acq_blk_log), 128'h50);
    check("evict_ld_data", 128'(rdata), 128'h112233445566778B);
    check("evict_ld_tag", 128'(rtag), 128'h1ab);

    do_req(40'h1400, 5'd0, 3'd3, 64'd0, 9'h0e, 1'b0);
    check("after_refill_hit_lat", 128'(lat), 128'd2);
    check("after_refill_hit_data", 128'(rdata), 128'h1122334455667788);
    check("after_refill_rel_n", 128'(rel_n), 128'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
